phase_err_avg: RTL and testbench

- Consumer of the DIFFDOE/DIFFDATA phase-difference stream produced by the dual-channel FFT phase-compare stage.
- Gates each phase sample by its FFT peak power (LTHMAXD) against a programmable threshold.
- Averages N accepted samples with ±π wrap handling and emits one steering-error word per window to the PID controller.
- Runs a loss-of-signal watchdog and a lock flag.

---
 rtl/fft_pkg.sv | 14 +
 rtl/phase_wrap.sv | 21 ++
 rtl/phase_err_avg.sv | 176 +++++++++++++++++
 tb/tb_phase_err_avg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Phase-domain constants shared by the FFT phase-compare stage and the
// steering-error averager, plus the averager state encoding.
package fft_pkg;
  localparam int PHASE_W      = 16;
  localparam int PI_CODE      = 25736;
  localparam int TWO_PI_CODE  = 51472;
  localparam int HALF_PI_CODE = 12868;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } avgState_t;
endpackage

// File: rtl/phase_wrap.sv
// Single-step +/-2*pi wrap of a signed phase word into [-PI_CODE, PI_CODE].
// One step is enough: every caller feeds values within one turn of the range.
module phase_wrap #(
  parameter int W       = 18,
  parameter int PI_CODE = fft_pkg::PI_CODE
) (
  input  logic signed [W-1:0] phaseIn,
  output logic signed [W-1:0] phaseOut
);
  localparam logic signed [W-1:0] PI_S     = W'(PI_CODE);
  localparam logic signed [W-1:0] TWO_PI_S = W'(2 * PI_CODE);

  // Fold anything beyond +/-pi back by one full turn.
  always_comb begin
    phaseOut = phaseIn;
    if (phaseIn > PI_S)
      phaseOut = phaseIn - TWO_PI_S;
    else if (phaseIn < -PI_S)
      phaseOut = phaseIn + TWO_PI_S;
  end
endmodule

// File: rtl/phase_err_avg.sv
// Power-gated, wrap-aware averager of the phase-difference stream. Emits one
// steering-error word per window of 2^AVG_LOG2 accepted samples, with a
// loss-of-signal watchdog, a lock flag and a rejected-sample counter.
module phase_err_avg import fft_pkg::*; #(
  parameter int AVG_LOG2    = 3,
  parameter int PI_CODE     = fft_pkg::PI_CODE,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      DIFFDOE,
  input  logic signed [PHASE_W-1:0] DIFFDATA,
  input  logic [54:0]               LTHMAXD,
  input  logic [54:0]               MAG_TH,
  input  logic                      CLR,
  output logic                      ERR_DOE,
  output logic signed [PHASE_W-1:0] ERR_DATA,
  output logic                      LOCK,
  output logic                      LOST,
  output logic [15:0]               REJCNT
);
  // Working width: one turn of headroom above a 16-bit phase word.
  localparam int PW    = 18;
  localparam int ACC_W = PW + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic signed [PW-1:0] TWO_PI_S  = PW'(2 * PI_CODE);
  localparam logic signed [PW-1:0] HALF_PI_S = PW'(PI_CODE / 2);
  localparam logic [CNT_W-1:0]     N_CNT     = CNT_W'(1 << AVG_LOG2);
  localparam logic [WD_W-1:0]      WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

  // Round half up, then divide by the window length.
  function automatic logic signed [PW-1:0] roundAvg(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + ACC_W'(1 << (AVG_LOG2 - 1))) >>> AVG_LOG2;
    return r[PW-1:0];
  endfunction

  avgState_t               state, nextState;
  logic signed [ACC_W-1:0] acc;
  logic signed [PW-1:0]    refPh;
  logic [CNT_W-1:0]        cnt;
  logic [WD_W-1:0]         wdog;

  logic signed [PW-1:0]    diffExt, wSamp, adjSamp;
  logic signed [PW-1:0]    avgRaw, avg_p0, avg_p1;
  logic                    vld_p0, vld_p1;
  logic                    accept, reject, wdExpire;
  logic                    loadFirst, addSamp, clrWin;

  assign diffExt  = PW'(DIFFDATA);
  assign accept   = DIFFDOE && (LTHMAXD >= MAG_TH) && !CLR;
  assign reject   = DIFFDOE && (LTHMAXD < MAG_TH) && !CLR;
  assign wdExpire = (wdog == WD_LAST) && !accept && !CLR;
  assign avgRaw   = roundAvg(acc);

  phase_wrap #(.W(PW), .PI_CODE(PI_CODE)) wrapIn  (.phaseIn(diffExt), .phaseOut(wSamp));
  phase_wrap #(.W(PW), .PI_CODE(PI_CODE)) wrapAvg (.phaseIn(avgRaw),  .phaseOut(avg_p0));

  // Unwrap a sample that straddles the +/-pi seam relative to the window reference.
  always_comb begin
    adjSamp = wSamp;
    if (((refPh > HALF_PI_S) || (refPh < -HALF_PI_S)) && (wSamp[PW-1] != refPh[PW-1]))
      adjSamp = refPh[PW-1] ? (wSamp - TWO_PI_S) : (wSamp + TWO_PI_S);
  end

  // Window FSM next state and datapath control; CLR and watchdog expiry abort.
  always_comb begin
    nextState = state;
    loadFirst = 1'b0;
    addSamp   = 1'b0;
    clrWin    = 1'b0;
    vld_p0    = 1'b0;
    if (CLR || wdExpire) begin
      nextState = IDLE;
      clrWin    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            loadFirst = 1'b1;
            nextState = ACC;
          end
        end
        ACC: begin
          if (accept) begin
            addSamp = 1'b1;
            if ((cnt + CNT_W'(1)) == N_CNT)
              nextState = OUT;
          end
        end
        OUT: begin
          vld_p0 = 1'b1;
          if (accept) begin
            loadFirst = 1'b1;
            nextState = ACC;
          end else begin
            clrWin    = 1'b1;
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Window accumulator, reference phase and sample count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc   <= '0;
      refPh <= '0;
      cnt   <= '0;
    end else if (loadFirst) begin
      acc   <= ACC_W'(wSamp);
      refPh <= wSamp;
      cnt   <= CNT_W'(1);
    end else if (addSamp) begin
      acc <= acc + ACC_W'(adjSamp);
      cnt <= cnt + CNT_W'(1);
    end else if (clrWin) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  // Stage p1: capture the wrapped average computed during the OUT cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1 <= 1'b0;
      avg_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) avg_p1 <= avg_p0;
    end
  end

  // Output stage: error strobe/word and lock flag; an abort drops a pending result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_DOE  <= 1'b0;
      ERR_DATA <= '0;
      LOCK     <= 1'b0;
    end else begin
      ERR_DOE <= vld_p1 && !CLR && !wdExpire;
      if (vld_p1 && !CLR && !wdExpire) ERR_DATA <= avg_p1[PHASE_W-1:0];
      if (CLR || wdExpire) LOCK <= 1'b0;
      else if (vld_p1)     LOCK <= 1'b1;
    end
  end

  // Loss-of-signal watchdog: cycles since the last accepted sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog <= '0;
      LOST <= 1'b0;
    end else begin
      LOST <= wdExpire;
      if (CLR || accept || wdExpire) wdog <= '0;
      else                           wdog <= wdog + WD_W'(1);
    end
  end

  // Saturating count of samples refused by the power threshold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                               REJCNT <= '0;
    else if (CLR)                          REJCNT <= '0;
    else if (reject && REJCNT != 16'hFFFF) REJCNT <= REJCNT + 16'd1;
  end
endmodule

// File: tb/tb_phase_err_avg.sv
// Bench for phase_err_avg: table of 8-sample windows with hand-derived
// averages, plus sequences for threshold, watchdog, CLR and RST corners.
module tb_phase_err_avg;
  localparam int TIMEOUT = 50;

  logic                CLK = 1'b0;
  logic                RST, DIFFDOE, CLR;
  logic signed [15:0]  DIFFDATA;
  logic [54:0]         LTHMAXD, MAG_TH;
  logic                ERR_DOE, LOCK, LOST;
  logic signed [15:0]  ERR_DATA;
  logic [15:0]         REJCNT;

  int     nVec = 0;
  int     nMis = 0;
  int     doeCount = 0;
  longint cyc = 0;
  longint lastCyc = 0;

  typedef struct { longint data; longint at; } exp_t;
  exp_t sb[$];
  exp_t popE;

  typedef struct packed { logic [7:0][15:0] d; logic [15:0] exp; } vec_t;
  vec_t tbl[$];

  phase_err_avg #(.AVG_LOG2(3), .PI_CODE(25736), .TIMEOUT_CYC(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .DIFFDOE(DIFFDOE), .DIFFDATA(DIFFDATA),
    .LTHMAXD(LTHMAXD), .MAG_TH(MAG_TH), .CLR(CLR),
    .ERR_DOE(ERR_DOE), .ERR_DATA(ERR_DATA), .LOCK(LOCK), .LOST(LOST), .REJCNT(REJCNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    nVec++;
    if (act != exp) begin
      nMis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every ERR_DOE pops one expected word and its due cycle.
  always @(negedge CLK) begin
    if (!RST && ERR_DOE) begin
      doeCount++;
      if (sb.size() == 0) chk("unexpected_err_doe", 1, 0);
      else begin
        popE = sb.pop_front();
        chk("err_data", ERR_DATA, popE.data);
        chk("err_latency", cyc, popE.at);
      end
    end
  end

  function automatic vec_t mk(input int s0, s1, s2, s3, s4, s5, s6, s7, input int e);
    vec_t v;
    v.d   = {16'(s7), 16'(s6), 16'(s5), 16'(s4), 16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    v.exp = 16'(e);
    return v;
  endfunction

  task automatic strobe(input logic signed [15:0] d, input logic [54:0] m, input logic c = 1'b0);
    DIFFDOE = 1'b1; DIFFDATA = d; LTHMAXD = m; CLR = c;
    @(posedge CLK); #1;
    lastCyc = cyc;
    DIFFDOE = 1'b0; CLR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic doClr();
    CLR = 1'b1; DIFFDOE = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b0;
  endtask

  task automatic pushExp(input longint d);
    exp_t e;
    e.data = d;
    e.at   = lastCyc + 2;
    sb.push_back(e);
  endtask

  task automatic waitDrain(input string nm);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge CLK);
    #1;
    chk({nm, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic window(input logic signed [15:0] d, input logic [54:0] m, input string nm);
    for (int i = 0; i < 8; i++) strobe(d, m);
    pushExp(d);
    waitDrain(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int     d0;
    logic   got;
    longint at, e;

    RST = 1'b1; CLR = 1'b0; DIFFDOE = 1'b0; DIFFDATA = '0; LTHMAXD = '0; MAG_TH = '0;
    repeat (3) @(negedge CLK);
    chk("rst_err_doe", ERR_DOE, 0);
    chk("rst_err_data", ERR_DATA, 0);
    chk("rst_lock", LOCK, 0);
    chk("rst_lost", LOST, 0);
    chk("rst_rejcnt", REJCNT, 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    tbl.push_back(mk(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000));
    tbl.push_back(mk(25000, -25000, 25000, -25000, 25000, -25000, 25000, -25000, 25736));
    tbl.push_back(mk(-25000, 25000, -25000, 25000, -25000, 25000, -25000, 25000, -25736));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(-4, -4, -4, -4, 0, 0, 0, 0, -2));
    tbl.push_back(mk(-30000, -30000, -30000, -30000, -30000, -30000, -30000, -30000, 21472));
    tbl.push_back(mk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, -18705));
    tbl.push_back(mk(12868, -12868, 12868, -12868, 12868, -12868, 12868, -12868, 0));
    tbl.push_back(mk(12869, -12869, 12869, -12869, 12869, -12869, 12869, -12869, 25736));
    tbl.push_back(mk(25000, -25000, -25000, -25000, -25000, -25000, -25000, -25000, -25184));
    tbl.push_back(mk(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000));
    tbl.push_back(mk(-25736, -25736, -25736, -25736, -25736, -25736, -25736, -25736, -25736));
    tbl.push_back(mk(25737, 25737, 25737, 25737, 25737, 25737, 25737, 25737, -25735));

    for (int k = 0; k < tbl.size(); k++) begin
      doClr();
      chk($sformatf("v%0d_lock_clr", k), LOCK, 0);
      for (int i = 0; i < 8; i++) strobe(signed'(tbl[k].d[i]), 55'd5);
      pushExp(signed'(tbl[k].exp));
      waitDrain($sformatf("v%0d", k));
      chk($sformatf("v%0d_lock", k), LOCK, 1);
    end

    // Power threshold gating: half the strobes fall one count short.
    MAG_TH = 55'd1000;
    doClr();
    for (int i = 0; i < 16; i++) strobe(16'sd500, (i % 2 == 0) ? 55'd999 : 55'd1000);
    pushExp(500);
    waitDrain("thr");
    chk("thr_rejcnt", REJCNT, 8);
    chk("thr_lock", LOCK, 1);

    // Watchdog: partial window then silence.
    MAG_TH = 55'd0;
    doClr();
    window(16'sd2000, 55'd1, "wd_pre");
    chk("wd_lock_pre", LOCK, 1);
    for (int i = 0; i < 3; i++) strobe(16'sd1000, 55'd1);
    e = lastCyc;
    got = 1'b0; at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (LOST) begin got = 1'b1; at = cyc; break; end
    end
    chk("wd_lost_seen", got, 1);
    chk("wd_lost_cycle", at, e + TIMEOUT);
    chk("wd_lock_after", LOCK, 0);
    @(negedge CLK);
    chk("wd_lost_single", LOST, 0);
    @(posedge CLK); #1;
    window(16'sd300, 55'd1, "wd_fresh");

    // CLR together with the 8th accepted strobe.
    MAG_TH = 55'd1000;
    doClr();
    strobe(16'sd0, 55'd3);
    window(16'sd700, 55'd2000, "clr_pre");
    chk("clr_rej_pre", REJCNT, 1);
    chk("clr_lock_pre", LOCK, 1);
    d0 = doeCount;
    for (int i = 0; i < 7; i++) strobe(16'sd700, 55'd2000);
    strobe(16'sd700, 55'd2000, 1'b1);
    idle(4);
    chk("clr8_no_doe", doeCount - d0, 0);
    chk("clr8_lock", LOCK, 0);
    chk("clr8_rejcnt", REJCNT, 0);
    window(-16'sd100, 55'd2000, "clr_fresh");

    // CLR during the OUT cycle.
    d0 = doeCount;
    for (int i = 0; i < 8; i++) strobe(16'sd40, 55'd2000);
    doClr();
    idle(4);
    chk("clrout_no_doe", doeCount - d0, 0);
    chk("clrout_err_kept", ERR_DATA, -100);
    chk("clrout_lock", LOCK, 0);

    // RST mid-window.
    window(16'sd1234, 55'd2000, "rst_pre");
    strobe(16'sd0, 55'd3);
    for (int i = 0; i < 4; i++) strobe(16'sd600, 55'd2000);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstmid_err_doe", ERR_DOE, 0);
    chk("rstmid_err_data", ERR_DATA, 0);
    chk("rstmid_lock", LOCK, 0);
    chk("rstmid_lost", LOST, 0);
    chk("rstmid_rejcnt", REJCNT, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    window(16'sd50, 55'd2000, "rst_fresh");
    chk("rst_fresh_lock", LOCK, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
